// File: rtl/gaussian_blur_3x3_pkg.sv
// gaussian_blur_3x3_pkg
// Shared types and constants for the 3x3 Gaussian smoothing stage of the
// Canny pipeline: pixel width, kernel weights and normalisation shift,
// FSM state encoding, window layout and the kernel arithmetic helper.
package gaussian_blur_3x3_pkg;

  localparam int unsigned PIXEL_BITS   = 8;
  localparam int unsigned SUM_BITS     = 12;
  localparam int unsigned KERNEL_SHIFT = 4;

  // Kernel [1 2 1; 2 4 2; 1 2 1]; total weight 16 = 2**KERNEL_SHIFT
  localparam int unsigned KERNEL_CORNER = 1;
  localparam int unsigned KERNEL_EDGE   = 2;
  localparam int unsigned KERNEL_CENTRE = 4;

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // One vertical slice of the window: top is the oldest line
  typedef struct packed {
    pixel_t top;
    pixel_t mid;
    pixel_t bot;
  } column_t;

  // Index 0 is the leftmost (oldest) column, index 2 the newest
  typedef column_t [2:0] window_t;

  function automatic logic [SUM_BITS-1:0] widen(input pixel_t p);
    return SUM_BITS'(p);
  endfunction

  // Weighted 3x3 sum; worst case 16*255 = 4080 fits in SUM_BITS
  function automatic logic [SUM_BITS-1:0] kernel_sum(input window_t w);
    logic [SUM_BITS-1:0] corners;
    logic [SUM_BITS-1:0] edges;
    logic [SUM_BITS-1:0] centre;
    corners = widen(w[0].top) + widen(w[2].top) + widen(w[0].bot) + widen(w[2].bot);
    edges   = widen(w[1].top) + widen(w[1].bot) + widen(w[0].mid) + widen(w[2].mid);
    centre  = widen(w[1].mid);
    return SUM_BITS'(KERNEL_CORNER) * corners
         + SUM_BITS'(KERNEL_EDGE)   * edges
         + SUM_BITS'(KERNEL_CENTRE) * centre;
  endfunction

endpackage

// File: rtl/gaussian_blur_3x3_line_buffer.sv
// gaussian_blur_3x3_line_buffer
// DEPTH-entry delay line for one image line. On each enabled cycle the
// pixel written DEPTH enables ago is presented on dout_c and replaced by din.
// Ports:
//   clock, reset : clock and asynchronous active-high reset (pointer only)
//   en           : advance the delay line by one pixel
//   din          : pixel entering the line
//   dout_c       : pixel delayed by DEPTH enables (combinational read)
module gaussian_blur_3x3_line_buffer
  import gaussian_blur_3x3_pkg::*;
#(
  parameter int unsigned DEPTH = 1920
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   en,
  input  pixel_t din,
  output pixel_t dout_c
);

  localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_BITS-1:0] PTR_LAST = PTR_BITS'(DEPTH - 1);

  pixel_t              mem [DEPTH];
  logic [PTR_BITS-1:0] ptr;

  // Read-before-write: the slot about to be overwritten holds the oldest pixel
  assign dout_c = mem[ptr];

  // Storage is never cleared; stale contents only ever reach border outputs
  always_ff @(posedge clock) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

  // Circular write pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_BITS'(1);
    end
  end

endmodule

// File: rtl/gaussian_blur_3x3.sv
// gaussian_blur_3x3
// Streaming 3x3 Gaussian smoothing between two first-word-fall-through
// FIFOs. Pixels arrive in raster order; exactly WIDTH*HEIGHT pixels leave
// per frame in the same order, with the one-pixel image border forced to 0.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   in_empty     : upstream FIFO empty
//   in_rd_en     : pop upstream FIFO (in_dout valid whenever ~in_empty)
//   in_dout      : grayscale input pixel
//   out_full     : downstream FIFO full
//   out_wr_en    : push downstream FIFO
//   out_din      : blurred output pixel
//   frame_done   : pulses with the write of the last pixel of a frame
module gaussian_blur_3x3
  import gaussian_blur_3x3_pkg::*;
#(
  parameter int unsigned WIDTH  = 1920,
  parameter int unsigned HEIGHT = 1080
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  input  logic [PIXEL_BITS-1:0] in_dout,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [PIXEL_BITS-1:0] out_din,
  output logic                  frame_done
);

  localparam int unsigned COL_BITS = $clog2(WIDTH);
  localparam int unsigned ROW_BITS = $clog2(HEIGHT);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(HEIGHT - 1);

  state_t state;
  state_t state_n;

  logic [COL_BITS-1:0] in_c;
  logic [ROW_BITS-1:0] in_r;
  logic [COL_BITS-1:0] o_c;
  logic [ROW_BITS-1:0] o_r;

  logic   out_valid;
  logic   out_last;
  pixel_t out_data;

  logic advance;
  logic pop;
  logic load;

  pixel_t              lb0_dout;
  pixel_t              lb1_dout;
  window_t             win;
  window_t             win_n;
  logic [SUM_BITS-1:0] sum;
  logic                border;
  pixel_t              result;

  logic in_at_fill_end;
  logic in_at_frame_end;
  logic out_at_frame_end;

  // Output handshake: the register may be refilled whenever it is empty or draining
  assign advance    = ~out_valid | ~out_full;
  assign out_wr_en  = out_valid & ~out_full;
  assign frame_done = out_wr_en & out_last;
  assign out_din    = out_data;
  assign pop        = in_rd_en;

  // Position decodes
  assign in_at_fill_end   = (in_r == ROW_BITS'(1)) && (in_c == '0);
  assign in_at_frame_end  = (in_r == ROW_LAST) && (in_c == COL_LAST);
  assign out_at_frame_end = (o_r == ROW_LAST) && (o_c == COL_LAST);
  assign border           = (o_r == '0) || (o_r == ROW_LAST) || (o_c == '0) || (o_c == COL_LAST);

  // Two line delays give the pixels directly above the incoming one
  gaussian_blur_3x3_line_buffer #(
    .DEPTH (WIDTH)
  ) u_lb0 (
    .clock  (clock),
    .reset  (reset),
    .en     (pop),
    .din    (in_dout),
    .dout_c (lb0_dout)
  );

  gaussian_blur_3x3_line_buffer #(
    .DEPTH (WIDTH)
  ) u_lb1 (
    .clock  (clock),
    .reset  (reset),
    .en     (pop),
    .din    (lb0_dout),
    .dout_c (lb1_dout)
  );

  // Window as it will look after this pop; the kernel uses it so that the
  // result for the centre is ready to load on the same edge as the pop
  always_comb begin
    win_n        = win;
    win_n[0]     = win[1];
    win_n[1]     = win[2];
    win_n[2].top = lb1_dout;
    win_n[2].mid = lb0_dout;
    win_n[2].bot = in_dout;
  end

  assign sum    = kernel_sum(win_n);
  assign result = ((state == ST_RUN) && !border) ? PIXEL_BITS'(sum >> KERNEL_SHIFT) : '0;

  // Window register; contents are don't-care until the border has passed
  always_ff @(posedge clock) begin
    if (pop) begin
      win <= win_n;
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_FILL;
    end else begin
      state <= state_n;
    end
  end

  // Next state, pop and load decisions
  always_comb begin
    state_n  = state;
    in_rd_en = 1'b0;
    load     = 1'b0;
    unique case (state)
      ST_FILL: begin
        // Priming pops produce no output, so back-pressure is irrelevant here
        in_rd_en = ~in_empty;
        if (in_rd_en && in_at_fill_end) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        in_rd_en = ~in_empty & advance;
        load     = in_rd_en;
        if (in_rd_en && in_at_frame_end) begin
          state_n = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Trailing WIDTH+1 outputs are all border pixels: no input needed
        load = advance;
        if (advance && out_at_frame_end) begin
          state_n = ST_FILL;
        end
      end
      default: begin
        state_n = ST_FILL;
      end
    endcase
  end

  // Input raster position of the next pixel to pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_c <= '0;
      in_r <= '0;
    end else if (pop) begin
      if (in_c == COL_LAST) begin
        in_c <= '0;
        in_r <= (in_r == ROW_LAST) ? '0 : in_r + ROW_BITS'(1);
      end else begin
        in_c <= in_c + COL_BITS'(1);
      end
    end
  end

  // Output raster position of the next centre to load
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_c <= '0;
      o_r <= '0;
    end else if (load) begin
      if (o_c == COL_LAST) begin
        o_c <= '0;
        o_r <= (o_r == ROW_LAST) ? '0 : o_r + ROW_BITS'(1);
      end else begin
        o_c <= o_c + COL_BITS'(1);
      end
    end
  end

  // Single output register feeding the downstream FIFO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_last  <= out_at_frame_end;
    end else if (out_wr_en) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gaussian_blur_3x3.sv
// tb_gaussian_blur_3x3
// Directed bench for gaussian_blur_3x3 on a 5x5 frame: constant, impulse
// and saturation images with hand-computed results, a random image under
// input/output stalls, back-to-back frames and reset in mid-frame.
module tb_gaussian_blur_3x3;

  localparam int W      = 5;
  localparam int H      = 5;
  localparam int N      = W * H;
  localparam int BUDGET = 4000;

  logic       clock;
  logic       reset;
  logic       in_empty;
  logic       in_rd_en;
  logic [7:0] in_dout;
  logic       out_full;
  logic       out_wr_en;
  logic [7:0] out_din;
  logic       frame_done;

  int checks;
  int errors;
  int fd_total;

  logic [7:0] src_q[$];
  logic [7:0] got_q[$];
  logic [7:0] nostall_q[$];
  logic       fd_q[$];
  int         pop_w_q[$];

  logic [7:0] img      [N];
  logic [7:0] rand_img [N];
  logic [7:0] exp_img  [N];

  gaussian_blur_3x3 #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_empty   (in_empty),
    .in_rd_en   (in_rd_en),
    .in_dout    (in_dout),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .out_din    (out_din),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit is_interior(input int i);
    int r;
    int c;
    r = i / W;
    c = i % W;
    return (r > 0) && (r < H - 1) && (c > 0) && (c < W - 1);
  endfunction

  // Reference blur over the whole stored image
  task automatic set_ref();
    int r;
    int c;
    int s;
    for (int i = 0; i < N; i++) begin
      r = i / W;
      c = i % W;
      s = 0;
      if (is_interior(i)) begin
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * int'(img[(r + dr) * W + c + dc]);
          end
        end
      end
      exp_img[i] = 8'(s >> 4);
    end
  endtask

  task automatic set_impulse();
    for (int i = 0; i < N; i++) begin
      img[i]     = 8'd0;
      exp_img[i] = 8'd0;
    end
    img[12]     = 8'd160;
    exp_img[12] = 8'd40;
    exp_img[7]  = 8'd20;
    exp_img[11] = 8'd20;
    exp_img[13] = 8'd20;
    exp_img[17] = 8'd20;
    exp_img[6]  = 8'd10;
    exp_img[8]  = 8'd10;
    exp_img[16] = 8'd10;
    exp_img[18] = 8'd10;
  endtask

  task automatic set_flat(input logic [7:0] v);
    for (int i = 0; i < N; i++) begin
      img[i]     = v;
      exp_img[i] = is_interior(i) ? v : 8'd0;
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++) begin
      img[i] = rand_img[i];
    end
    set_ref();
  endtask

  task automatic load_src();
    for (int i = 0; i < N; i++) begin
      src_q.push_back(img[i]);
    end
  endtask

  task automatic start_capture();
    got_q.delete();
    fd_q.delete();
    pop_w_q.delete();
    fd_total = 0;
  endtask

  // Plays src_q into the DUT and captures writes until n_exp writes have been
  // seen with the source drained, then idles for tail more cycles
  task automatic run_stream(input int n_exp, input int tail, input bit stall_in, input bit stall_out);
    bit popped;
    bit done;
    int idle;
    popped = 1'b0;
    done   = 1'b0;
    idle   = 0;
    for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
      @(posedge clock);
      #1;
      if (popped) void'(src_q.pop_front());
      popped   = 1'b0;
      in_empty = (src_q.size() == 0) || (stall_in && ($urandom_range(0, 2) == 0));
      in_dout  = (src_q.size() != 0) ? src_q[0] : 8'h00;
      out_full = stall_out && ($urandom_range(0, 1) == 1);
      @(negedge clock);
      if (in_rd_en) begin
        check_eq("rd_en_while_empty", 32'(in_empty), 32'd0);
        popped = 1'b1;
        pop_w_q.push_back(got_q.size());
      end
      if (frame_done) fd_total++;
      if (out_wr_en) begin
        got_q.push_back(out_din);
        fd_q.push_back(frame_done);
      end
      if (got_q.size() >= n_exp && src_q.size() <= (popped ? 1 : 0)) begin
        if (idle >= tail) done = 1'b1;
        idle++;
      end
    end
    check_eq("stream_done", 32'(done), 32'd1);
    if (popped) void'(src_q.pop_front());
  endtask

  task automatic compare_frame(input string tag, input int base);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("%s_px%0d", tag, i), 32'(got_q[base + i]), 32'(exp_img[i]));
      check_eq($sformatf("%s_fd%0d", tag, i), 32'(fd_q[base + i]), 32'(i == N - 1));
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    fd_total = 0;
    reset    = 1'b1;
    in_empty = 1'b1;
    in_dout  = 8'h00;
    out_full = 1'b0;
    for (int i = 0; i < N; i++) rand_img[i] = 8'($urandom_range(0, 255));

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_wr_en", 32'(out_wr_en), 32'd0);
    check_eq("rst_dout", 32'(out_din), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_rd_en", 32'(in_rd_en), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Constant 100: interior 1600>>4 = 100
    set_flat(8'd100);
    start_capture();
    load_src();
    run_stream(N, 20, 1'b0, 1'b0);
    check_eq("c100_count", 32'(got_q.size()), 32'(N));
    check_eq("c100_fd_total", 32'(fd_total), 32'd1);
    compare_frame("c100", 0);

    // Impulse 160 at centre
    set_impulse();
    start_capture();
    load_src();
    run_stream(N, 20, 1'b0, 1'b0);
    check_eq("imp_count", 32'(got_q.size()), 32'(N));
    compare_frame("imp", 0);

    // Saturation: 4080>>4 = 255
    set_flat(8'd255);
    start_capture();
    load_src();
    run_stream(N, 20, 1'b0, 1'b0);
    check_eq("c255_count", 32'(got_q.size()), 32'(N));
    compare_frame("c255", 0);

    // Random image, no stalls, then the same image under random stalls
    set_random();
    start_capture();
    load_src();
    run_stream(N, 20, 1'b0, 1'b0);
    check_eq("rnd_count", 32'(got_q.size()), 32'(N));
    compare_frame("rnd", 0);
    nostall_q = got_q;

    start_capture();
    load_src();
    run_stream(N, 20, 1'b1, 1'b1);
    check_eq("stall_count", 32'(got_q.size()), 32'(N));
    check_eq("stall_fd_total", 32'(fd_total), 32'd1);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("stall_px%0d", i), 32'(got_q[i]), 32'(nostall_q[i]));
    end

    // Back-to-back: impulse frame then random frame with no gap at the source
    start_capture();
    set_impulse();
    load_src();
    set_random();
    load_src();
    run_stream(2 * N, 20, 1'b0, 1'b0);
    check_eq("b2b_count", 32'(got_q.size()), 32'(2 * N));
    check_eq("b2b_pops", 32'(pop_w_q.size()), 32'(2 * N));
    check_eq("b2b_fd_total", 32'(fd_total), 32'd2);
    // First pop of frame 2 coincides with the last write of frame 1
    check_eq("b2b_pop_gap", 32'(pop_w_q[N]), 32'(N - 1));
    compare_frame("b2b_f2", N);
    set_impulse();
    compare_frame("b2b_f1", 0);

    // Reset after 13 pops of a ramp frame, then a full random frame
    start_capture();
    for (int i = 0; i < 13; i++) src_q.push_back(8'(i * 7 + 3));
    run_stream(0, 0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset    = 1'b1;
    in_empty = 1'b1;
    #1;
    check_eq("mid_rst_wr_en", 32'(out_wr_en), 32'd0);
    check_eq("mid_rst_dout", 32'(out_din), 32'd0);
    check_eq("mid_rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    src_q.delete();
    start_capture();
    set_random();
    load_src();
    run_stream(N, 20, 1'b0, 1'b0);
    check_eq("post_rst_count", 32'(got_q.size()), 32'(N));
    compare_frame("post_rst", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gaussian_blur_3x3.md
Name: gaussian_blur_3x3

Overview:
- Streaming 3x3 Gaussian smoothing stage directly downstream of the grayscale stage in the Canny pipeline.
- Pops 8-bit grayscale pixels from the grayscale output FIFO and pushes 8-bit blurred pixels into the next FIFO, which feeds the Sobel stage.
- Uses two line buffers and a 3x3 window; pixel order is raster.
- Emits exactly WIDTH*HEIGHT pixels per frame, with image borders forced to zero.

Parameters:
- WIDTH, 1920, pixels per line (>=3)
- HEIGHT, 1080, lines per frame (>=3)

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- in_empty  in  1  upstream FIFO empty
- in_rd_en  out  1  pop upstream FIFO; in_dout valid whenever ~in_empty (first-word-fall-through)
- in_dout  in  8  grayscale pixel
- out_full  in  1  downstream FIFO full
- out_wr_en  out  1  push downstream FIFO
- out_din  out  8  blurred pixel
- frame_done  out  1  one-cycle pulse on the write of the last pixel of a frame

Behaviour:
- Reset (async, active-high):
  - state=FILL; all counters=0; out_valid reg=0.
  - out_wr_en=0, in_rd_en=0, frame_done=0, out_din=0.
  - Line-buffer and window contents are not cleared; border forcing makes this harmless.
- Kernel: [1 2 1; 2 4 2; 1 2 1].
  - Sum is 12-bit unsigned (max 4080); out_din = sum[11:4], truncating with no rounding.
- Pipeline:
  - One output register (out_valid, out_data).
  - advance = ~out_valid | ~out_full.
  - out_wr_en = out_valid & ~out_full, combinational.
- Counters: input col/row (in_c, in_r) and output col/row (o_c, o_r), each wrapping at WIDTH-1 / HEIGHT-1.
- State FILL:
  - in_rd_en = ~in_empty (no back-pressure dependence).
  - Each pop shifts the line buffers and window; no output is produced.
  - After WIDTH+1 pops, go to RUN.
- State RUN:
  - in_rd_en = ~in_empty & advance.
  - Each pop shifts the window and loads the output register with the result for centre (o_r, o_c).
  - If o_r==0, o_r==HEIGHT-1, o_c==0 or o_c==WIDTH-1, the loaded value is 0; otherwise it is the kernel result.
  - When the pop is input pixel (HEIGHT-1, WIDTH-1), go to FLUSH.
- State FLUSH:
  - in_rd_en=0.
  - On each advance, load a zero pixel and increment the output counters.
  - These WIDTH+1 trailing pixels are all border pixels.
  - After WIDTH+1 loads, go to FILL for the next frame.
- Latency: centre pixel (r,c) is loaded one cycle after input index r*WIDTH+c+WIDTH+1 is popped.
- Ordering: output count and order are identical to input raster order. No pixel is dropped or duplicated under any out_full/in_empty pattern.
- frame_done: asserted in the cycle where out_wr_en=1 and the output register holds output (HEIGHT-1, WIDTH-1).
- Simultaneous events:
  - A pop and a write in the same cycle is the normal RUN throughput of 1 pixel/clock.
  - in_empty during RUN inserts a bubble; out_valid drops when the register drains.
- Back-to-back frames: FLUSH must complete before any pop of the next frame.
- Reset mid-frame: all state is discarded; the next popped pixel is treated as (0,0).

Decomposition:
- Shared canny package: PIXEL_BITS=8, kernel weights, KERNEL_SHIFT=4, state encoding (FILL, RUN, FLUSH).
- One sub-module is natural: line_buffer (WIDTH-deep, 8-bit shift/RAM delay line, instantiated twice).
- Kernel arithmetic stays inline.

Test Plan:
- WIDTH=5, HEIGHT=5, constant 100, no stalls -> 25 writes; 9 interior pixels =100; 16 border =0; frame_done on write 25 only.
- WIDTH=5, HEIGHT=5, impulse 160 at (2,2), else 0 -> (2,2)=40; (1,2),(2,1),(2,3),(3,2)=20; (1,1),(1,3),(3,1),(3,3)=10; rest 0.
- Constant 255 -> interior 255 (4080>>4), no overflow; borders 0.
- Random out_full (50%) and random in_empty -> output sequence bit-identical to the no-stall run; in_rd_en never asserted while in_empty.
- Two back-to-back frames -> exactly 2*WIDTH*HEIGHT writes; second frame output identical to a single-frame run; no pop of frame 2 during FLUSH.
- Assert reset after 13 pops of frame 1, then feed a full frame -> outputs go to 0 immediately; new frame output correct; 25 writes after reset.
